sap_datapath: RTL and testbench
===============================

# sap_datapath

Phase-driven accumulator datapath that sits directly downstream of the `control` sequencer. It consumes the sequencer's one-hot phase strobes S0–S5 and executes a 4-bit-address, 8-bit-data instruction set: fetch, decode, and a three-phase execute per instruction. It drives the external program/data memory address and presents results on a registered output port. It halts on HLT.

## Interface
- `PC_RESET`, default 4'h0: PC value after reset and after CLR.
- `CHECK_ONEHOT`, default 1: 1 enables phase-strobe legality checking and `PHASE_ERR`.

- `CLK`  in  1  rising-edge clock, shared with `control`
- `RESET_N`  in  1  asynchronous, active-low reset
- `CLR`  in  1  synchronous clear, same signal fed to `control`
- `S0`–`S5`  in  1 each  one-hot phase strobes from `control`
- `MEM_DATA`  in  8  memory read data, combinational from `MEM_ADDR`
- `MEM_ADDR`  out  4  memory address (MAR contents)
- `OUT_DATA`  out  8  output register
- `OUT_VALID`  out  1  one-cycle pulse when `OUT_DATA` is written
- `CARRY`, `ZERO`  out  1 each  ALU flags
- `HALT`  out  1  sticky; set by HLT
- `PHASE_ERR`  out  1  sticky; illegal strobe pattern seen

## Operation
- Registers: PC[3:0], MAR[3:0], IR[7:0], A[7:0], B[7:0], OUT_DATA, and the flags.
- Instruction format: IR[7:4] is the opcode; IR[3:0] is the operand address.
- Opcodes:
  - 0 LDA
  - 1 ADD
  - 2 SUB
  - 3 JMP
  - 4 JZ
  - E OUT
  - F HLT
  - all others NOP
- Per phase, at the rising edge where the strobe is high:
  - S0: MAR←PC.
  - S1: PC←PC+1, modulo 16. PC 15 wraps to 0.
  - S2: IR←MEM_DATA.
  - S3, by opcode:
    - LDA/ADD/SUB: MAR←IR[3:0].
    - JMP: PC←IR[3:0].
    - JZ: PC←IR[3:0] only if ZERO=1.
    - OUT: OUT_DATA←A, OUT_VALID←1.
    - HLT: HALT←1.
  - S4: LDA: A←MEM_DATA. ADD/SUB: B←MEM_DATA.
  - S5:
    - ADD: {CARRY,A}←A+B (9-bit sum).
    - SUB: A←A−B mod 256; CARRY←(A≥B), i.e. CARRY means no borrow.
    - ZERO←(new A==0) on both ADD and SUB.
    - LDA does not change the flags.
- Unlisted opcode/phase combinations change nothing.
- Priority at each edge: RESET_N > CLR > HALT inhibit > phase actions.
- CLR=1:
  - PC←PC_RESET; A, B, IR, MAR, OUT_DATA, CARRY, ZERO, HALT←0.
  - PHASE_ERR is retained.
  - Any strobe in that cycle is ignored.
- HALT=1: no register updates until RESET_N or CLR. MEM_ADDR holds.
- Illegal strobe (zero strobes or ≥2 strobes high) with CHECK_ONEHOT=1:
  - No register updates that cycle.
  - PHASE_ERR←1; sticky until RESET_N only.
- Illegal strobe with CHECK_ONEHOT=0:
  - Zero strobes is an idle cycle.
  - Multiple strobes: behaviour undefined; not tested.

## Timing
- All state updates on the rising CLK edge. RESET_N acts immediately and asynchronously.
- Reset values:
  - PC=PC_RESET
  - MEM_ADDR=0
  - OUT_DATA=0, OUT_VALID=0
  - CARRY=0, ZERO=0
  - HALT=0, PHASE_ERR=0
- MEM_DATA is sampled in the same cycle MAR drives MEM_ADDR. S2 and S4 each require MAR loaded at least one edge earlier, which S0 and S3 guarantee.
- Instruction latency: 6 strobe cycles, S0 through S5.
- OUT_VALID is high for exactly the one cycle following the S3 edge of an OUT instruction, and is low otherwise.
- HALT asserts in the cycle after the HLT S3 edge.
- RESET_N asserted mid-instruction abandons the instruction. After release, execution resumes from PC_RESET at the next S0.

## Structure
- Shared package `sap_pkg`:
  - opcode localparams: OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_OUT, OP_HLT
  - widths: DATA_W=8, ADDR_W=4
  - one-hot phase index constants PH_S0..PH_S5
- One combinational sub-module `sap_alu`:
  - inputs: a, b, sub
  - outputs: result[7:0], carry, zero
- `sap_datapath` holds all registers, decode, and the one-hot check.

## Test plan
- Load program: mem[0]=09, mem[1]=1A, mem[2]=E0, mem[3]=F0, mem[9]=05, mem[A]=07. Run from reset → OUT_DATA=0C, OUT_VALID pulses once, HALT=1 after the fourth instruction, PC=4, CARRY=0, ZERO=0.
- With A=03: SUB operand 05 → A=FE, CARRY=0, ZERO=0. Then LDA 80, ADD 80 → A=00, CARRY=1, ZERO=1.
- With ZERO=1 and mem[0]=4C: JZ → next fetch from address C. With ZERO=0: fetch continues at address 1. Separately, PC=F, run S1 → PC wraps to 0.
- HALT then more strobes → no register change. CLR pulse → PC=0, HALT=0, and execution restarts. CLR coincident with an S5 ADD → A=00, ADD discarded.
- Strobe errors: drive S2 and S4 together, then all strobes low → PHASE_ERR=1, no register change. CLR → PHASE_ERR stays 1. RESET_N low → PHASE_ERR=0.
- Assert RESET_N low between S3 and S4 of LDA → all outputs at reset values immediately. After release, next S0 fetches from mem[0].

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP accumulator datapath.
package sap_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned NUM_PH = 6;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_JMP = 4'h3;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h4;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam int unsigned PH_S0 = 0;
    localparam int unsigned PH_S1 = 1;
    localparam int unsigned PH_S2 = 2;
    localparam int unsigned PH_S3 = 3;
    localparam int unsigned PH_S4 = 4;
    localparam int unsigned PH_S5 = 5;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // True when exactly one phase strobe is high.
    function automatic logic is_onehot(input logic [NUM_PH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(NUM_PH); i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit; carry on subtract means no borrow.
module sap_alu
    import sap_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    localparam int unsigned SUM_W = DATA_W + 1;

    logic [DATA_W-1:0] b_eff;
    logic [SUM_W-1:0]  sum;

    // Subtraction as a + ~b + 1 so the carry-out is the no-borrow flag.
    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = SUM_W'(a) + SUM_W'(b_eff) + SUM_W'(sub);
    end

    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];
    assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// Phase-strobed SAP datapath: fetch, decode and three-phase execute driven by S0..S5.
module sap_datapath
    import sap_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET     = 4'h0,
    parameter bit                CHECK_ONEHOT = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLR,
    input  logic              S0,
    input  logic              S1,
    input  logic              S2,
    input  logic              S3,
    input  logic              S4,
    input  logic              S5,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    output logic              CARRY,
    output logic              ZERO,
    output logic              HALT,
    output logic              PHASE_ERR
);

    logic [NUM_PH-1:0] phase;
    logic              phase_bad;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    instr_t            ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign phase     = {S5, S4, S3, S2, S1, S0};
    assign phase_bad = CHECK_ONEHOT && !is_onehot(phase);
    assign MEM_ADDR  = mar;

    sap_alu u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .sub    (ir.op == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Architectural registers; CLR outranks halt, halt outranks strobe actions.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc        <= PC_RESET;
            mar       <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
            HALT      <= 1'b0;
            PHASE_ERR <= 1'b0;
        end else if (CLR) begin
            pc        <= PC_RESET;
            mar       <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
            HALT      <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (!HALT) begin
                if (phase_bad) begin
                    PHASE_ERR <= 1'b1;
                end else begin
                    if (phase[PH_S0]) mar <= pc;
                    if (phase[PH_S1]) pc <= pc + ADDR_W'(1);
                    if (phase[PH_S2]) ir <= instr_t'(MEM_DATA);
                    if (phase[PH_S3]) begin
                        case (ir.op)
                            OP_LDA, OP_ADD, OP_SUB: mar <= ir.addr;
                            OP_JMP: pc <= ir.addr;
                            OP_JZ:  if (ZERO) pc <= ir.addr;
                            OP_OUT: begin
                                OUT_DATA  <= a_reg;
                                OUT_VALID <= 1'b1;
                            end
                            OP_HLT: HALT <= 1'b1;
                            default: ;
                        endcase
                    end
                    if (phase[PH_S4]) begin
                        case (ir.op)
                            OP_LDA:         a_reg <= MEM_DATA;
                            OP_ADD, OP_SUB: b_reg <= MEM_DATA;
                            default: ;
                        endcase
                    end
                    if (phase[PH_S5] && (ir.op == OP_ADD || ir.op == OP_SUB)) begin
                        a_reg <= alu_result;
                        CARRY <= alu_carry;
                        ZERO  <= alu_zero;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed program scenarios plus randomized programs against an instruction-level model.
module tb_sap_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [5:0] ph;
    logic [7:0] mem_data;
    logic [3:0] mem_addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       carry;
    logic       zero;
    logic       halt;
    logic       phase_err;

    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;
    int ov_pulses = 0;

    // Instruction-level reference state.
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;
    logic       m_ov, m_c, m_z, m_halt, m_perr;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    sap_datapath dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .CLR       (clr),
        .S0        (ph[0]),
        .S1        (ph[1]),
        .S2        (ph[2]),
        .S3        (ph[3]),
        .S4        (ph[4]),
        .S5        (ph[5]),
        .MEM_DATA  (mem_data),
        .MEM_ADDR  (mem_addr),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .CARRY     (carry),
        .ZERO      (zero),
        .HALT      (halt),
        .PHASE_ERR (phase_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_a = 8'h00; m_b = 8'h00;
        m_out = 8'h00; m_ov = 1'b0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_perr = 1'b0;
    endfunction

    function automatic void model_clr();
        logic keep;
        keep = m_perr;
        model_reset();
        m_perr = keep;
    endfunction

    // One clock edge of the architecture, from the instruction semantics.
    function automatic void model_edge(input logic [5:0] p);
        int         r;
        logic [3:0] op;
        logic [7:0] md;
        m_ov = 1'b0;
        if (m_halt) return;
        if ($countones(p) != 1) begin
            m_perr = 1'b1;
            return;
        end
        op = m_ir[7:4];
        md = mem[m_mar];
        if (p[0]) m_mar = m_pc;
        else if (p[1]) m_pc = 4'((int'(m_pc) + 1) % 16);
        else if (p[2]) m_ir = md;
        else if (p[3]) begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) m_mar = m_ir[3:0];
            else if (op == 4'h3) m_pc = m_ir[3:0];
            else if (op == 4'h4 && m_z) m_pc = m_ir[3:0];
            else if (op == 4'hE) begin m_out = m_a; m_ov = 1'b1; end
            else if (op == 4'hF) m_halt = 1'b1;
        end else if (p[4]) begin
            if (op == 4'h0) m_a = md;
            else if (op == 4'h1 || op == 4'h2) m_b = md;
        end else if (p[5]) begin
            if (op == 4'h1) begin
                r   = int'(m_a) + int'(m_b);
                m_c = (r > 255);
                m_a = 8'(r % 256);
                m_z = (m_a == 8'h00);
            end else if (op == 4'h2) begin
                m_c = (m_a >= m_b);
                r   = int'(m_a) - int'(m_b);
                if (r < 0) r += 256;
                m_a = 8'(r);
                m_z = (m_a == 8'h00);
            end
        end
    endfunction

    task automatic compare_all();
        chk("mem_addr",  {4'h0, mem_addr},  {4'h0, m_mar});
        chk("out_data",  out_data,          m_out);
        chk("out_valid", {7'h0, out_valid}, {7'h0, m_ov});
        chk("carry",     {7'h0, carry},     {7'h0, m_c});
        chk("zero",      {7'h0, zero},      {7'h0, m_z});
        chk("halt",      {7'h0, halt},      {7'h0, m_halt});
        chk("phase_err", {7'h0, phase_err}, {7'h0, m_perr});
    endtask

    task automatic cyc(input logic [5:0] p, input logic c);
        @(negedge clk);
        ph  = p;
        clr = c;
        @(posedge clk);
        if (c) model_clr();
        else model_edge(p);
        #1;
        if (out_valid) ov_pulses++;
        compare_all();
    endtask

    task automatic run_instr();
        for (int i = 0; i < 6; i++) cyc(6'b000001 << i, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs checked before any clock.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ph    = 6'b000001;
        clr   = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_addr",  {4'h0, mem_addr},  8'h00);
        chk("rst_out_data",  out_data,          8'h00);
        chk("rst_out_valid", {7'h0, out_valid}, 8'h00);
        chk("rst_carry",     {7'h0, carry},     8'h00);
        chk("rst_zero",      {7'h0, zero},      8'h00);
        chk("rst_halt",      {7'h0, halt},      8'h00);
        chk("rst_phase_err", {7'h0, phase_err}, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) mem[i] = 8'h50;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [5:0] bad;
        logic [3:0] op_pick [10];
        rst_n = 1'b0;
        clr   = 1'b0;
        ph    = 6'b000000;
        op_pick = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF, 4'h5, 4'h0, 4'h1};
        fill_nop();
        model_reset();
        do_reset();

        // Basic program: 5 + 7 output, then halt.
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[9] = 8'h05; mem[10] = 8'h07;
        ov_pulses = 0;
        for (int k = 0; k < 4; k++) run_instr();
        chk("p1_out",    out_data,          8'h0C);
        chk("p1_pulses", 8'(ov_pulses),     8'd1);
        chk("p1_halt",   {7'h0, halt},      8'h01);
        chk("p1_pc",     {4'h0, dut.pc},    8'h04);
        chk("p1_carry",  {7'h0, carry},     8'h00);
        chk("p1_zero",   {7'h0, zero},      8'h00);

        // Halted: further strobes change nothing.
        run_instr();
        chk("halt_hold_pc", {4'h0, dut.pc}, 8'h04);
        chk("halt_hold_pulses", 8'(ov_pulses), 8'd1);

        cyc(6'b000001, 1'b1);
        chk("clr_pc",   {4'h0, dut.pc}, 8'h00);
        chk("clr_halt", {7'h0, halt},   8'h00);

        // SUB/ADD flags and JZ taken.
        fill_nop();
        mem[0] = 8'h09; mem[1] = 8'h2A; mem[2] = 8'hE0; mem[3] = 8'h0B;
        mem[4] = 8'h1B; mem[5] = 8'h4D; mem[6] = 8'hF0;
        mem[9] = 8'h03; mem[10] = 8'h05; mem[11] = 8'h80;
        mem[13] = 8'hE0; mem[14] = 8'hF0;
        for (int k = 0; k < 3; k++) run_instr();
        chk("sub_out",   out_data,      8'hFE);
        chk("sub_carry", {7'h0, carry}, 8'h00);
        chk("sub_zero",  {7'h0, zero},  8'h00);
        run_instr();
        run_instr();
        chk("add_carry", {7'h0, carry}, 8'h01);
        chk("add_zero",  {7'h0, zero},  8'h01);
        run_instr();
        cyc(6'b000001, 1'b0);
        chk("jz_taken", {4'h0, mem_addr}, 8'h0D);
        for (int i = 1; i < 6; i++) cyc(6'b000001 << i, 1'b0);
        chk("jz_out", out_data, 8'h00);

        // JZ not taken with ZERO clear.
        cyc(6'b000001, 1'b1);
        mem[0] = 8'h4C;
        run_instr();
        cyc(6'b000001, 1'b0);
        chk("jz_not_taken", {4'h0, mem_addr}, 8'h01);
        for (int i = 1; i < 6; i++) cyc(6'b000001 << i, 1'b0);

        // PC wrap from F to 0.
        cyc(6'b000001, 1'b1);
        fill_nop();
        mem[0] = 8'h3F;
        run_instr();
        cyc(6'b000001, 1'b0);
        chk("wrap_fetch", {4'h0, mem_addr}, 8'h0F);
        cyc(6'b000010, 1'b0);
        chk("wrap_pc", {4'h0, dut.pc}, 8'h00);
        for (int i = 2; i < 6; i++) cyc(6'b000001 << i, 1'b0);
        cyc(6'b000001, 1'b0);
        chk("wrap_next", {4'h0, mem_addr}, 8'h00);
        for (int i = 1; i < 6; i++) cyc(6'b000001 << i, 1'b0);

        // CLR on the ADD execute edge discards the add.
        cyc(6'b000001, 1'b1);
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[9] = 8'h05; mem[10] = 8'h07;
        run_instr();
        for (int i = 0; i < 5; i++) cyc(6'b000001 << i, 1'b0);
        cyc(6'b100000, 1'b1);
        chk("clr_s5_pc", {4'h0, dut.pc}, 8'h00);
        mem[0] = 8'hE0;
        run_instr();
        chk("clr_s5_a", out_data, 8'h00);

        // Illegal strobe patterns.
        cyc(6'b000001, 1'b0);
        cyc(6'b000010, 1'b0);
        cyc(6'b010100, 1'b0);
        chk("perr_multi", {7'h0, phase_err}, 8'h01);
        chk("perr_pc_hold", {4'h0, dut.pc}, 8'h02);
        cyc(6'b000000, 1'b0);
        chk("perr_none_pc", {4'h0, dut.pc}, 8'h02);
        cyc(6'b000001, 1'b1);
        chk("perr_after_clr", {7'h0, phase_err}, 8'h01);
        do_reset();
        chk("perr_after_rst", {7'h0, phase_err}, 8'h00);

        // Reset mid-LDA, then restart from address 0.
        mem[0] = 8'h09; mem[1] = 8'hE0; mem[2] = 8'h0B; mem[9] = 8'hAA; mem[11] = 8'h33;
        run_instr();
        run_instr();
        chk("pre_rst_out", out_data, 8'hAA);
        for (int i = 0; i < 4; i++) cyc(6'b000001 << i, 1'b0);
        do_reset();
        cyc(6'b000001, 1'b0);
        chk("rst_refetch", {4'h0, mem_addr}, 8'h00);
        for (int i = 1; i < 6; i++) cyc(6'b000001 << i, 1'b0);
        run_instr();
        chk("rst_resume_out", out_data, 8'hAA);

        // Randomized programs against the model.
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = {op_pick[$urandom_range(0, 9)], 4'($urandom_range(0, 15))};
                if ($urandom_range(0, 2) == 0) mem[i] = 8'($urandom);
            end
            cyc(6'b000001, 1'b1);
            for (int k = 0; k < 14; k++) begin
                for (int i = 0; i < 6; i++) begin
                    if (!m_halt && $urandom_range(0, 59) == 0) begin
                        bad = 6'($urandom);
                        if ($countones(bad) == 1) bad = 6'b000000;
                        cyc(bad, 1'b0);
                    end
                    if ($urandom_range(0, 119) == 0) cyc(6'b000001 << i, 1'b1);
                    else cyc(6'b000001 << i, 1'b0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
